// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the flexible FIFO used as the TX/RX buffer between
// the SPI shift engine and the user-side logic.
//   fifo_mode_e : read-path mode (registered read or first-word-fall-through)
//   ptr_width() : pointer width for a given depth (address bits + wrap bit)
//   SPI_*       : default geometry for the SPI TX/RX instances
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum int {
        FIFO_STD  = 0,
        FIFO_FWFT = 1
    } fifo_mode_e;

    // Pointers carry one extra bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int SPI_FIFO_WIDTH     = 8;
    localparam int SPI_FIFO_DEPTH     = 8;
    localparam int SPI_TX_MODE        = int'(FIFO_STD);
    localparam int SPI_RX_MODE        = int'(FIFO_FWFT);
    localparam int SPI_FIFO_AF_THRESH = SPI_FIFO_DEPTH - 2;
    localparam int SPI_FIFO_AE_THRESH = 1;

endpackage

// File: rtl/fifo_flex_mem.sv
// -----------------------------------------------------------------------------
// fifo_flex_mem
// Simple dual-port storage for fifo_flex. One synchronous write port and one
// read port that is either synchronous (registered, BRAM-friendly) or
// asynchronous (LUTRAM-style), chosen by ASYNC_READ.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (synchronous mode only)
//   rd_addr  : read address
//   rd_data  : read data (registered or combinational)
// Contents are never reset.
// -----------------------------------------------------------------------------
module fifo_flex_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter bit ASYNC_READ = 1'b0
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    generate
        if (ASYNC_READ) begin : g_async_rd
            assign rd_data = mem_q[rd_addr];
            // Read strobe has no meaning for a combinational read port.
            logic unused_rd_en;
            assign unused_rd_en = rd_en;
        end else begin : g_sync_rd
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_data_q <= mem_q[rd_addr];
                end
            end
            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_flex.sv
// -----------------------------------------------------------------------------
// fifo_flex
// Parametrised synchronous FIFO with optional first-word-fall-through read,
// occupancy count, almost-full/almost-empty flags and sticky error flags.
//   clk, rst     : clock, asynchronous active-high reset
//   writeData    : word to push          writeEn : push request
//   readEn       : pop request (acknowledge in FWFT mode)
//   readData     : popped word (FWFT=0) or head word (FWFT=1)
//   errClr       : clears overflow/underflow
//   full, empty, almostFull, almostEmpty, count : occupancy status
//   overflow     : sticky, push attempted while full
//   underflow    : sticky, pop attempted while empty
// Status outputs are decoded from the pointer registers, so they follow an
// accepted push/pop one cycle after the accepting edge.
// -----------------------------------------------------------------------------
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         writeData,
    input  logic                     writeEn,
    input  logic                     readEn,
    output logic [WIDTH-1:0]         readData,
    input  logic                     errClr,
    output logic                     full,
    output logic                     empty,
    output logic                     almostFull,
    output logic                     almostEmpty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam bit FWFT_MODE = (FWFT == int'(FIFO_FWFT));

    // Elaboration-time parameter checks.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_flex: DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("fifo_flex: AF_THRESH out of range 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("fifo_flex: AE_THRESH out of range 0..DEPTH-1");
        end
        if (FWFT != int'(FIFO_STD) && FWFT != int'(FIFO_FWFT)) begin : g_bad_mode
            $error("fifo_flex: FWFT must be 0 or 1");
        end
    endgenerate

    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [PTR_W-1:0] count_w;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] mem_rdata;

    // Occupancy: pointer difference modulo 2*DEPTH.
    assign count_w     = wr_ptr_q - rd_ptr_q;
    assign count       = count_w;
    assign full        = (count_w == DEPTH_C);
    assign empty       = (count_w == '0);
    assign almostFull  = (count_w >= AF_C);
    assign almostEmpty = (count_w <= AE_C);

    assign push_ok = writeEn && !full;
    assign pop_ok  = readEn && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Sticky errors; a new error in the same cycle as errClr wins.
    always_comb begin
        overflow_d  = (writeEn && full) || (overflow_q && !errClr);
        underflow_d = (readEn && empty) || (underflow_q && !errClr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A push never targets the head slot while it holds live data (that would
    // require full, and pushes are rejected when full), so there is no
    // read/write collision on the memory.
    fifo_flex_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .ASYNC_READ (FWFT_MODE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (writeData),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (mem_rdata)
    );

    generate
        if (FWFT_MODE) begin : g_fwft
            // Head word straight from the memory; forced to zero while empty
            // so reset shows readData = 0 without a separate register.
            assign readData = empty ? '0 : mem_rdata;
        end else begin : g_std
            // The memory read register carries no reset (keeps it inferable as
            // block RAM). rd_valid marks whether it has been loaded since
            // reset, giving readData = 0 out of reset, asynchronously.
            logic rd_valid_q, rd_valid_d;

            always_comb begin
                rd_valid_d = rd_valid_q || pop_ok;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign readData = rd_valid_q ? mem_rdata : '0;
        end
    endgenerate

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous FIFO. Successor to the SPI slave byte FIFO; used as the TX/RX buffer between the SPI shift engine and the user-side logic.
- Adds the following over the previous generation:
  - first-word-fall-through (FWFT) mode, selectable per instance
  - occupancy count
  - programmable almost-full and almost-empty flags
  - guarded push/pop
  - sticky overflow and underflow error flags
- Single clock domain.

Parameters:
- WIDTH, default 8: data word width in bits, ≥1.
- DEPTH, default 8: number of entries. Must be a power of two, ≥2.
- FWFT, default 0: 0 = standard registered read; 1 = head word is presented on readData without a read request.
- AF_THRESH, default DEPTH-2: almostFull asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- AE_THRESH, default 1: almostEmpty asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- writeData  in  WIDTH  word to push.
- writeEn  in  1  push request.
- readEn  in  1  pop request.
- readData  out  WIDTH  popped word (FWFT=0) or head word (FWFT=1).
- errClr  in  1  clears the overflow and underflow flags.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count ≥ AF_THRESH.
- almostEmpty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - Pointers = 0, readData = 0, full = 0, empty = 1, count = 0.
  - almostFull = 0; almostEmpty = 1.
  - overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Reset asserted mid-operation: all in-flight data is discarded. empty = 1 is visible immediately (asynchronously). The first push after rst deasserts behaves as a push into an empty FIFO.
- Pointers: wrPtr and rdPtr are ADDR_W+1 bits wide, where ADDR_W = $clog2(DEPTH).
  - The low ADDR_W bits index memory; the MSB is the wrap bit.
  - Both pointers wrap naturally modulo 2·DEPTH.
  - count = wrPtr − rdPtr, computed modulo 2^(ADDR_W+1).
- Accepted push: writeEn && !full. Increments wrPtr and stores the word at wrPtr.
- Accepted pop: readEn && !empty. Increments rdPtr.
- full, empty, count, almostFull and almostEmpty are decoded combinationally from the pointer registers. They therefore reflect a push or pop one cycle after the accepting edge.
- Simultaneous push and pop:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the pop is accepted, the push is rejected, and overflow is set.
  - Empty: the push is accepted, the pop is rejected, and underflow is set.
- Rejected operations never move a pointer or corrupt memory.
- overflow is set on (writeEn && full); underflow is set on (readEn && empty).
  - Both flags hold until errClr.
  - If errClr and a set condition occur in the same cycle, set wins.
- FWFT=0 read path:
  - readData is registered; it is loaded with mem[rdPtr] on an accepted pop.
  - The popped word is visible on the cycle after the pop edge.
  - readData holds its value otherwise, including on rejected pops.
- FWFT=1 read path:
  - readData = mem[rdPtr] combinationally and is valid whenever empty = 0. readEn acts as the acknowledge.
  - A word pushed into an empty FIFO appears on readData, with empty = 0, one cycle after the push edge.
  - While empty = 1, readData is don't-care.
- Thresholds are checked at elaboration. Out-of-range values, or a non-power-of-two DEPTH, cause an elaboration error.

Decomposition:
- Package fifo_pkg:
  - enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - function clog2-based ptr_width(depth)
  - localparam defaults for the SPI TX/RX instances.
- Sub-module fifo_mem: simple dual-port RAM with one write port, a synchronous read port, and an asynchronous read port selected by parameter. It isolates BRAM/LUTRAM inference.
- fifo_flex contains the pointers, flags, error logic and read register.

Test Plan:
- All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless noted.
- FWFT=0, fill and drain:
  - Push 0x10..0x17 on consecutive cycles → count steps 1..8; almostFull rises when count = 6; full = 1 after the 8th push.
  - Then pop 8 times → readData = 0x10..0x17 each one cycle after its pop; empty = 1 at the end.
- Overflow and simultaneous ops at full:
  - When full, assert writeEn and readEn together with data 0xAA → pop accepted, push rejected, overflow = 1, count = 7, and 0xAA never appears on readData.
  - Pulse errClr → overflow = 0.
- Underflow and pointer wrap:
  - Pop while empty → underflow = 1, readData unchanged, count = 0.
  - Run 20 push/pop pairs with data 0x00..0x13, each word popped one cycle after it is pushed → every word is read back in order across the pointer wrap, and count never exceeds 1.
- FWFT=1 head presentation:
  - Push 0x5A into an empty FIFO → next cycle empty = 0 and readData = 0x5A with no readEn.
  - Push 0x5B, then pop → readData = 0x5B on the following cycle.
- Asynchronous reset mid-stream:
  - With 5 entries held, assert rst between clock edges → empty = 1, count = 0, overflow = 0, readData = 0 immediately.
  - After release, push 0x77 and pop → 0x77 is returned.
- Errors and thresholds:
  - errClr asserted in the same cycle as a new overflow → overflow remains 1.
  - almostEmpty = 1 at counts 0 and 1, and 0 at count 2.
